// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// The pipeline controller decode and the hazard unit's MDU-class flag use these too.
package mdu_sched_pkg;

    localparam int MD_OP_W = 3;

    // MDU operation encodings carried from decode into E stage
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

    // Sequencer states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // True for the ops that occupy the unit for a multi-cycle sequence
    function automatic logic isLongOp(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// Pipeline <-> MDU signal bundle: E-stage issue, D-stage hazard query, HI/LO results.
interface mdu_sched_if;
    import mdu_sched_pkg::*;

    logic               start;
    logic [MD_OP_W-1:0] op;
    logic [31:0]        a;
    logic [31:0]        b;
    logic               md_D;
    logic               busy;
    logic               stall_md;
    logic [31:0]        hi;
    logic [31:0]        lo;

    modport master (
        output start, op, a, b, md_D,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, a, b, md_D,
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/mdu_sched_calc.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu, including the
// divide-by-zero and signed-overflow cases that MIPS leaves to the implementation.
module mdu_sched_calc
    import mdu_sched_pkg::*;
(
    input  logic [MD_OP_W-1:0] op_i,
    input  logic [31:0]        a_i,
    input  logic [31:0]        b_i,
    output logic [63:0]        result_o
);

    logic signed [31:0] quot;
    logic signed [31:0] rem;

    // Select the arithmetic for the op; divide-by-zero and INT_MIN/-1 are pinned so no X leaks
    always_comb begin
        result_o = '0;
        quot     = '0;
        rem      = '0;
        case (op_i)
            MD_MULT: begin
                result_o = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
            end
            MD_MULTU: begin
                result_o = {32'h0, a_i} * {32'h0, b_i};
            end
            MD_DIV: begin
                if (b_i == 32'h0) begin
                    result_o = {a_i, 32'hFFFF_FFFF};
                end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                    result_o = {32'h0, 32'h8000_0000};
                end else begin
                    quot     = $signed(a_i) / $signed(b_i);
                    rem      = $signed(a_i) % $signed(b_i);
                    result_o = {rem, quot};
                end
            end
            MD_DIVU: begin
                if (b_i == 32'h0) begin
                    result_o = {a_i, 32'hFFFF_FFFF};
                end else begin
                    result_o = {a_i % b_i, a_i / b_i};
                end
            end
            default: begin
                result_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide sequencer: owns HI/LO, runs a fixed-latency busy window for
// mult/div, writes mthi/mtlo immediately, and stalls D-stage MDU instructions.
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    mdu_sched_if.slave   mdu
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pendHi_q, pendHi_d;
    logic [31:0]      pendLo_q, pendLo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      calcResult;
    logic             busy;

    mdu_sched_calc u_calc (
        .op_i     (mdu.op),
        .a_i      (mdu.a),
        .b_i      (mdu.b),
        .result_o (calcResult)
    );

    // Next-state: accept a new op only in IDLE, otherwise count down and retire the pending result
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pendHi_d = pendHi_q;
        pendLo_d = pendLo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == ST_IDLE) begin
            if (mdu.start) begin
                if (isLongOp(mdu.op)) begin
                    state_d              = ST_RUN;
                    {pendHi_d, pendLo_d} = calcResult;
                    if (mdu.op == MD_MULT || mdu.op == MD_MULTU) begin
                        cnt_d = CNT_W'(MULT_CYCLES);
                    end else begin
                        cnt_d = CNT_W'(DIV_CYCLES);
                    end
                end else if (mdu.op == MD_MTHI) begin
                    hi_d = mdu.a;
                end else if (mdu.op == MD_MTLO) begin
                    lo_d = mdu.a;
                end
            end
        end else begin
            if (cnt_q == CNT_W'(1)) begin
                hi_d    = pendHi_q;
                lo_d    = pendLo_q;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers; reset discards any in-flight op without touching HI/LO with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pendHi_q <= '0;
            pendLo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pendHi_q <= pendHi_d;
            pendLo_q <= pendLo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy         = (state_q == ST_RUN);
    assign mdu.busy     = busy;
    assign mdu.stall_md = mdu.md_D & (mdu.start | busy);
    assign mdu.hi       = hi_q;
    assign mdu.lo       = lo_q;

endmodule
